// File: rtl/pc_unit_ras.sv
// pc_unit_ras: fetch-stage program counter with a return-address stack for CALL/RETURN.
// Define PCU_RAS_EN to build the stack; without it CALL acts as JUMP, RETURN as SEQ, status outputs are constant.
module pc_unit_ras #(
  parameter int               WIDTH        = 16,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       pc_src,
  input  logic             pc_enable,
  input  logic             clear_err,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam logic [2:0] SRC_SEQ    = 3'd0;
  localparam logic [2:0] SRC_BRANCH = 3'd1;
  localparam logic [2:0] SRC_JUMP   = 3'd2;
  localparam logic [2:0] SRC_CALL   = 3'd3;
  localparam logic [2:0] SRC_RETURN = 3'd4;

  logic [WIDTH-1:0] pc_next;

  assign pc_plus1 = pc + WIDTH'(1);

`ifdef PCU_RAS_EN
  localparam int              PW        = $clog2(RAS_DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [CW-1:0]   COUNT_MAX = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [0:RAS_DEPTH-1];
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] ras_top;
  logic             push;
  logic             pop;
  logic             ovf_q;
  logic             unf_q;

  // wr_ptr addresses the next free slot; the newest entry sits one below it
  assign ras_top       = ras_mem[wr_ptr - PW'(1)];
  assign ras_empty     = (count == '0);
  assign ras_full      = (count == COUNT_MAX);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    if (pc_enable) begin
      case (pc_src)
        SRC_SEQ:    pc_next = pc_plus1;
        SRC_BRANCH: pc_next = a;
        SRC_JUMP:   pc_next = b;
        SRC_CALL: begin
          pc_next = b;
          push    = 1'b1;
        end
        SRC_RETURN: begin
          pc_next = ras_empty ? RESET_VECTOR : ras_top;
          pop     = 1'b1;
        end
        default:    pc_next = pc;
      endcase
    end
  end

  // Storage is not reset; count/pointer decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      ras_mem[wr_ptr] <= pc_plus1;
    end
  end

  // When full, wr_ptr already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (!ras_full) begin
        count <= count + CW'(1);
      end
    end else if (pop && !ras_empty) begin
      wr_ptr <= wr_ptr - PW'(1);
      count  <= count - CW'(1);
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (push && ras_full) || (ovf_q && !clear_err);
      unf_q <= (pop && ras_empty) || (unf_q && !clear_err);
    end
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic          unused_clear_err;

  assign unused_clear_err = clear_err;
  assign ras_empty        = 1'b1;
  assign ras_full         = 1'b0;
  assign ras_overflow     = 1'b0;
  assign ras_underflow    = 1'b0;

  always_comb begin
    pc_next = pc;
    if (pc_enable) begin
      case (pc_src)
        SRC_SEQ:    pc_next = pc_plus1;
        SRC_BRANCH: pc_next = a;
        SRC_JUMP:   pc_next = b;
        SRC_CALL:   pc_next = b;
        SRC_RETURN: pc_next = pc_plus1;
        default:    pc_next = pc;
      endcase
    end
  end
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed and randomized checks of pc_unit_ras against a queue-based model.
// Follows the PCU_RAS_EN define of the build so both configurations are covered.
module tb_pc_unit_ras;

  localparam int          WIDTH = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RV    = 16'h0000;
`ifdef PCU_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [2:0]        pc_src;
  logic              pc_enable;
  logic              clear_err;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  pc_plus1;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;

  pc_unit_ras #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .CLK(CLK), .reset(reset), .a(a), .b(b), .pc_src(pc_src),
    .pc_enable(pc_enable), .clear_err(clear_err), .pc(pc), .pc_plus1(pc_plus1),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_pc;
  bit          m_ovf;
  bit          m_unf;
  logic [15:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [15:0] exp_p1;
    exp_p1 = m_pc + 16'd1;
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".pc_plus1"}, 32'(pc_plus1), 32'(exp_p1));
    check({tag, ".empty"}, 32'(ras_empty), RAS_EN ? 32'(m_ras.size() == 0) : 32'd1);
    check({tag, ".full"}, 32'(ras_full), RAS_EN ? 32'(m_ras.size() == DEPTH) : 32'd0);
    check({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = RV;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive on the falling edge, advance the model, compare 1 ns after the rising edge.
  task automatic step(input logic [2:0] src, input bit en, input logic [15:0] aa,
                      input logic [15:0] bb, input bit clr, input string tag);
    logic [15:0] n_pc;
    logic [15:0] inc;
    bit          so;
    bit          su;
    @(negedge CLK);
    pc_src = src; pc_enable = en; a = aa; b = bb; clear_err = clr;
    inc = m_pc + 16'd1;
    n_pc = m_pc;
    so = 1'b0;
    su = 1'b0;
    if (en) begin
      case (src)
        3'd0: n_pc = inc;
        3'd1: n_pc = aa;
        3'd2: n_pc = bb;
        3'd3: begin
          n_pc = bb;
          if (RAS_EN) begin
            if (m_ras.size() == DEPTH) begin
              void'(m_ras.pop_front());
              so = 1'b1;
            end
            m_ras.push_back(inc);
          end
        end
        3'd4: begin
          if (!RAS_EN) n_pc = inc;
          else if (m_ras.size() > 0) n_pc = m_ras.pop_back();
          else begin
            n_pc = RV;
            su = 1'b1;
          end
        end
        default: n_pc = m_pc;
      endcase
    end
    m_ovf = so || (m_ovf && !clr);
    m_unf = su || (m_unf && !clr);
    @(posedge CLK);
    #1;
    m_pc = n_pc;
    check_state(tag);
  endtask

  // Reset asserted between edges; enable dropped so the deassert edge holds state.
  task automatic async_reset(input string tag);
    @(posedge CLK);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_state(tag);
    pc_enable = 1'b0;
    clear_err = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0]  src;
    logic [15:0] aa;
    logic [15:0] bb;
    int          r;

    reset = 1'b1; a = '0; b = '0; pc_src = '0; pc_enable = 1'b0; clear_err = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_state("reset");
    check("reset.p1_const", 32'(pc_plus1), 32'h0001);
    @(negedge CLK);
    reset = 1'b0;

    // sequential count
    for (int i = 0; i < 3; i++) step(3'd0, 1'b1, 16'h0, 16'h0, 1'b0, "seq");
    check("seq.pc3", 32'(pc), 32'h0003);
    check("seq.p1", 32'(pc_plus1), 32'h0004);

    // call/return pair
    step(3'd1, 1'b1, 16'h0010, 16'h0, 1'b0, "br10");
    step(3'd3, 1'b1, 16'h0, 16'h0200, 1'b0, "call");
    check("call.pc", 32'(pc), 32'h0200);
    step(3'd0, 1'b1, 16'h0, 16'h0, 1'b0, "seq_a");
    step(3'd0, 1'b1, 16'h0, 16'h0, 1'b0, "seq_b");
    check("seq_b.pc", 32'(pc), 32'h0202);
    step(3'd4, 1'b1, 16'h0, 16'h0, 1'b0, "ret");
    check("ret.pc", 32'(pc), RAS_EN ? 32'h0011 : 32'h0203);

    // overflow then underflow, then clear
    async_reset("rst2");
    for (int i = 1; i <= 5; i++) step(3'd3, 1'b1, 16'h0, 16'(i * 256), 1'b0, "call5");
    check("call5.ovf", 32'(ras_overflow), 32'(RAS_EN));
    for (int i = 0; i < 5; i++) step(3'd4, 1'b1, 16'h0, 16'h0, 1'b0, "ret5");
    check("ret5.pc", 32'(pc), RAS_EN ? 32'h0000 : 32'h0505);
    check("ret5.unf", 32'(ras_underflow), 32'(RAS_EN));
    step(3'd0, 1'b1, 16'h0, 16'h0, 1'b1, "clr");
    check("clr.ovf", 32'(ras_overflow), 32'd0);

    // wrap, reserved code, disabled call
    step(3'd1, 1'b1, 16'hFFFF, 16'h0, 1'b0, "brff");
    step(3'd0, 1'b1, 16'h0, 16'h0, 1'b0, "wrap");
    check("wrap.pc", 32'(pc), 32'h0000);
    step(3'd3, 1'b1, 16'h0, 16'h0700, 1'b0, "call7");
    step(3'd6, 1'b1, 16'h1234, 16'h5678, 1'b0, "rsvd");
    check("rsvd.pc", 32'(pc), 32'h0700);
    step(3'd3, 1'b0, 16'h0, 16'h0900, 1'b0, "hold");
    check("hold.pc", 32'(pc), 32'h0700);

    // reset mid-call sequence
    step(3'd3, 1'b1, 16'h0, 16'h0300, 1'b0, "mc1");
    step(3'd3, 1'b1, 16'h0, 16'h0400, 1'b0, "mc2");
    async_reset("midrst");
    check("midrst.empty", 32'(ras_empty), 32'd1);
    step(3'd4, 1'b1, 16'h0, 16'h0, 1'b0, "midret");
    check("midret.pc", 32'(pc), RAS_EN ? 32'h0000 : 32'h0001);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r   = $urandom_range(0, 99);
      src = (r < 25) ? 3'd3 : (r < 50) ? 3'd4 : 3'($urandom_range(0, 7));
      aa  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      bb  = 16'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
      else step(src, $urandom_range(0, 9) != 0, aa, bb, $urandom_range(0, 9) == 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
# pc_unit_ras

Parametrised program-counter unit for the processor fetch stage: holds the PC, computes the sequential increment, and selects among branch, jump, call and return targets. It adds a hardware return-address stack (RAS) so call/return pairs resolve without a register-file round trip. It sits between the control unit (which drives `pc_src` and `pc_enable`) and instruction memory (which consumes `pc`).

## Interface
- `WIDTH`, 16: PC and target width in bits (≥ 4).
- `RAS_DEPTH`, 4: return-address stack entries (power of two, 2–16).
- `RESET_VECTOR`, 0: PC value loaded on reset; return target on stack underflow.

- `CLK`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `a`  in  WIDTH  branch target.
- `b`  in  WIDTH  jump/call target.
- `pc_src`  in  3  next-PC select (encoding under Operation).
- `pc_enable`  in  1  PC/stack update enable; low = full hold.
- `clear_err`  in  1  synchronous clear of sticky error flags.
- `pc`  out  WIDTH  current PC (registered).
- `pc_plus1`  out  WIDTH  `pc + 1` (combinational, link value).
- `ras_empty`  out  1  stack holds 0 entries.
- `ras_full`  out  1  stack holds `RAS_DEPTH` entries.
- `ras_overflow`  out  1  sticky: push occurred while full.
- `ras_underflow`  out  1  sticky: pop occurred while empty.

## Operation
- `pc_src` encoding, effective only when `pc_enable`=1 at the rising edge:
  - 0 SEQ: `pc <= pc+1`.
  - 1 BRANCH: `pc <= a`.
  - 2 JUMP: `pc <= b`.
  - 3 CALL: `pc <= b`; push `pc+1` onto RAS.
  - 4 RETURN: `pc <=` top of RAS; pop.
  - 5–7 reserved: `pc` held, no stack effect, no flag change.
- Arithmetic: `pc+1` is modulo 2^WIDTH; all-ones wraps to 0, no flag.
- RAS: circular buffer, write pointer plus saturating count (0..`RAS_DEPTH`).
  - Push while not full: write entry, count+1.
  - Push while full: overwrite oldest entry (pointer advances, count stays `RAS_DEPTH`), set `ras_overflow`.
  - Pop while not empty: return most recent entry, count−1.
  - Pop while empty: `pc <= RESET_VECTOR`, count stays 0, set `ras_underflow`.
- `pc_enable`=0: `pc`, stack contents, pointer, count held; flags updated only by `clear_err`.
- `clear_err`=1: both sticky flags cleared at the edge; if the same edge also sets a flag, set wins.
- `ras_empty` = (count==0), `ras_full` = (count==`RAS_DEPTH`), both derived from registered count.

## Timing
- Reset (asynchronous assert, any time incl. mid-call): `pc`=`RESET_VECTOR`, count=0, pointer=0, `ras_empty`=1, `ras_full`=0, both flags 0; `pc_plus1`=`RESET_VECTOR`+1. Stack entry contents need not be cleared.
- Reset deassertion: first update on the first rising edge with `reset` low.
- Latency: selection at edge N visible on `pc` after edge N; one cycle for every `pc_src` code.
- `pc_plus1` follows `pc` combinationally in the same cycle.
- Back-to-back CALL/RETURN on consecutive cycles allowed; RETURN immediately after CALL returns the address pushed on the prior edge.
- Status outputs (`ras_empty`, `ras_full`, flags) update on the same edge as the causing operation.

## Configuration
- `PCU_RAS_EN` defined: RAS, CALL/RETURN semantics and RAS status outputs as above.
- `PCU_RAS_EN` undefined: no stack storage; CALL behaves as JUMP (`pc <= b`); RETURN behaves as SEQ (`pc <= pc+1`); `ras_empty`=1, `ras_full`=0, `ras_overflow`=0, `ras_underflow`=0 constantly; port list unchanged.

## Test plan
Defaults WIDTH=16, RAS_DEPTH=4, RESET_VECTOR=0, `PCU_RAS_EN` defined unless stated.
- Reset then 3 cycles SEQ, enable=1 -> `pc` 0,1,2,3; `pc_plus1`=4; `ras_empty`=1.
- pc=0x0010, CALL b=0x0200, then 2 SEQ, then RETURN -> `pc` 0x0200,0x0201,0x0202,0x0011; `ras_empty` 0 then 1.
- 5 CALLs from pc=0x0000 to b=0x0100,0x0200,0x0300,0x0400,0x0500 then 5 RETURNs -> returns 0x0501? no: pops 0x0401,0x0301,0x0201,0x0101 then `RESET_VECTOR` 0x0000; `ras_overflow`=1 after 5th call, `ras_underflow`=1 after 5th return; `clear_err` clears both next edge.
- pc=0xFFFF, SEQ -> `pc`=0x0000, no flag; `pc_src`=6 -> `pc` held; `pc_enable`=0 with CALL -> `pc` and count unchanged.
- Assert `reset` mid-cycle after 2 CALLs (not at an edge) -> `pc`=0 and `ras_empty`=1 before next edge; subsequent RETURN -> `pc`=0, `ras_underflow`=1.
- `PCU_RAS_EN` undefined: pc=0x0010, CALL b=0x0200 then RETURN -> `pc` 0x0200, 0x0201; all RAS status outputs constant.
